// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: parking-lot barrier sequencer, occupancy counter and status flags
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sensor_a   debounced outer sensor (1 = vehicle present)
//   sensor_b   debounced inner sensor (1 = vehicle present)
//   occupancy  cars currently inside (saturates at CAPACITY and at 0)
//   full       occupancy == CAPACITY
//   empty      occupancy == 0
//   gate_open  barrier raise command
//   car_in     one-cycle pulse, entry completed
//   car_out    one-cycle pulse, exit completed
//   denied     one-cycle pulse, entry attempted while full
//   err        sticky over/underflow attempt or fault entered
//   fault      FSM is in FAULT
//
// Optional macro PARK_TIMEOUT_EN builds a stall counter that forces FAULT
// when a passage sits on one sensor pattern for TIMEOUT_CYC cycles.
module parking_gate_ctrl #(
    parameter int CAPACITY    = 16,
    parameter int CNT_W       = 5,
    parameter int TIMEOUT_CYC = 24000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_a,
    input  logic             sensor_b,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             gate_open,
    output logic             car_in,
    output logic             car_out,
    output logic             denied,
    output logic             err,
    output logic             fault
);
    typedef enum logic [2:0] {IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, FAULT} state_t;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    if ((1 << CNT_W) <= CAPACITY || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("parking_gate_ctrl: CNT_W too narrow for CAPACITY or TIMEOUT_CYC < 1");
    end

    state_t           state, ns;
    logic [1:0]       s;
    logic             full_lat, lat_n, inc, dec, deny, ovf, gate_n;
    logic [CNT_W-1:0] occ_n;
    logic             timeout;

    assign s = {sensor_a, sensor_b};

`ifdef PARK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] stall;
    logic [1:0]    s_prev;
    // stall holds how many sampled cycles s has kept its current value
    assign timeout = state != IDLE && state != FAULT && s == s_prev && stall >= TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall  <= '0;
            s_prev <= 2'b00;
        end else begin
            s_prev <= s;
            stall  <= s != s_prev ? TW'(1) : (state == IDLE || state == FAULT) ? '0 : stall + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        ns = state;
        case (state)
            IDLE:   ns = s == 2'b10 ? IN_A  : s == 2'b01 ? OUT_B  : s == 2'b11 ? FAULT : IDLE;
            IN_A:   ns = s == 2'b11 ? IN_AB : s == 2'b00 ? IDLE   : s == 2'b01 ? FAULT : IN_A;
            IN_AB:  ns = s == 2'b01 ? IN_B  : s == 2'b10 ? IN_A   : IN_AB;
            IN_B:   ns = s == 2'b00 ? IDLE  : s == 2'b11 ? IN_AB  : s == 2'b10 ? FAULT : IN_B;
            OUT_B:  ns = s == 2'b11 ? OUT_BA : s == 2'b00 ? IDLE  : s == 2'b10 ? FAULT : OUT_B;
            OUT_BA: ns = s == 2'b10 ? OUT_A : s == 2'b01 ? OUT_B  : OUT_BA;
            OUT_A:  ns = s == 2'b00 ? IDLE  : s == 2'b11 ? OUT_BA : s == 2'b01 ? FAULT : OUT_A;
            FAULT:  ns = s == 2'b00 ? IDLE  : FAULT;
            default: ns = IDLE;
        endcase
        if (timeout) ns = FAULT;
    end

    always_comb begin
        inc    = state == IN_B && ns == IDLE;
        dec    = state == OUT_A && ns == IDLE;
        deny   = state == IDLE && ns == IN_A && full;
        ovf    = (inc && occupancy == CAP) || (dec && occupancy == '0);
        occ_n  = ovf ? occupancy : inc ? occupancy + 1'b1 : dec ? occupancy - 1'b1 : occupancy;
        // full status is frozen at the start of an entry so the gate decision holds for the passage
        lat_n  = state == IDLE && ns == IN_A ? full : full_lat;
        gate_n = (ns == IN_A || ns == IN_AB || ns == IN_B) ? !lat_n : (ns == OUT_B || ns == OUT_BA || ns == OUT_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            full_lat  <= 1'b0;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            gate_open <= 1'b0;
            car_in    <= 1'b0;
            car_out   <= 1'b0;
            denied    <= 1'b0;
            err       <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= ns;
            full_lat  <= lat_n;
            occupancy <= occ_n;
            full      <= occ_n == CAP;
            empty     <= occ_n == '0;
            gate_open <= gate_n;
            car_in    <= inc;
            car_out   <= dec;
            denied    <= deny;
            err       <= err | ovf | (ns == FAULT);
            fault     <= ns == FAULT;
        end
    end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed scenarios for the parking gate controller
module tb_parking_gate_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_a = 1'b0;
    logic       sensor_b = 1'b0;
    logic [4:0] occupancy;
    logic       full, empty, gate_open, car_in, car_out, denied, err, fault;
    int         errors = 0;
    int         checks = 0;

    parking_gate_ctrl dut (
        .clk(clk), .rst_n(rst_n), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .occupancy(occupancy), .full(full), .empty(empty), .gate_open(gate_open),
        .car_in(car_in), .car_out(car_out), .denied(denied), .err(err), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic step(input logic a, input logic b);
        sensor_a = a;
        sensor_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic pass(input logic [7:0] seq);
        for (int i = 3; i >= 0; i--) step(seq[2*i+1], seq[2*i]);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(0, 0);
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if ({full, empty, gate_open, car_in, car_out, denied, err, fault} !== 8'b0100_0000) begin
            errors++; $display("FAIL reset_flags: got %b want 01000000", {full, empty, gate_open, car_in, car_out, denied, err, fault});
        end
        rst_n = 1'b1;
        step(0, 0);
    endtask

    task automatic test_entry;
        int pulses = 0;
        int gate_bad = 0;
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 5; c++) begin
                step(seq[p][1], seq[p][0]);
                if (car_in) pulses++;
                if (p < 3 && gate_open !== 1'b1) gate_bad++;
                if (p == 3 && c == 0) begin
                    checks++; if (car_in !== 1'b1) begin errors++; $display("FAIL entry_pulse_time: got %b want 1", car_in); end
                end
            end
        end
        checks++; if (gate_bad != 0) begin errors++; $display("FAIL entry_gate: low cycles %0d want 0", gate_bad); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL entry_pulses: got %0d want 1", pulses); end
        checks++; if (occupancy !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL entry_occ: got %0d empty %b want 1 empty 0", occupancy, empty); end
        checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL entry_gate_close: got %b want 0", gate_open); end
    endtask

    task automatic test_exit;
        int pulses = 0;
        int gate_bad = 0;
        logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        pass(8'b10_11_01_00);
        pass(8'b10_11_01_00);
        checks++; if (occupancy !== 5'd3) begin errors++; $display("FAIL exit_pre_occ: got %0d want 3", occupancy); end
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 5; c++) begin
                step(seq[p][1], seq[p][0]);
                if (car_out) pulses++;
                if (p < 3 && gate_open !== 1'b1) gate_bad++;
            end
        end
        checks++; if (gate_bad != 0) begin errors++; $display("FAIL exit_gate: low cycles %0d want 0", gate_bad); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL exit_pulses: got %0d want 1", pulses); end
        checks++; if (occupancy !== 5'd2) begin errors++; $display("FAIL exit_occ: got %0d want 2", occupancy); end
    endtask

    task automatic test_fault_backout;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pre_fault_err: got %b want 0", err); end
        step(1, 1);
        checks++; if ({fault, err, gate_open} !== 3'b110) begin errors++; $display("FAIL fault_enter: got %b want 110", {fault, err, gate_open}); end
        step(1, 1);
        checks++; if (fault !== 1'b1 || occupancy !== 5'd2) begin errors++; $display("FAIL fault_hold: got fault %b occ %0d want 1 2", fault, occupancy); end
        step(0, 0);
        checks++; if (fault !== 1'b0 || occupancy !== 5'd2 || err !== 1'b1) begin errors++; $display("FAIL fault_leave: got fault %b occ %0d err %b want 0 2 1", fault, occupancy, err); end
        step(1, 0);
        checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL backout_gate: got %b want 1", gate_open); end
        step(0, 0);
        checks++; if ({car_in, car_out, denied, gate_open} !== 4'b0000 || occupancy !== 5'd2) begin
            errors++; $display("FAIL backout: got pulses/gate %b occ %0d want 0000 2", {car_in, car_out, denied, gate_open}, occupancy);
        end
    endtask

    task automatic test_full;
        for (int i = 0; i < 14; i++) pass(8'b10_11_01_00);
        checks++; if (occupancy !== 5'd16 || full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL full_fill: got occ %0d full %b want 16 1", occupancy, full); end
        step(1, 0);
        checks++; if ({denied, gate_open, full} !== 3'b101) begin errors++; $display("FAIL full_deny: got %b want 101", {denied, gate_open, full}); end
        step(1, 0);
        checks++; if (denied !== 1'b0) begin errors++; $display("FAIL full_deny_width: got %b want 0", denied); end
        step(1, 1);
        checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL full_gate_ab: got %b want 0", gate_open); end
        step(0, 1);
        step(0, 0);
        checks++; if ({car_in, occupancy, full} !== {1'b1, 5'd16, 1'b1}) begin errors++; $display("FAIL forced_entry: got car_in %b occ %0d full %b want 1 16 1", car_in, occupancy, full); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL forced_err: got %b want 1", err); end
    endtask

    task automatic test_async_reset;
        step(1, 0);
        step(1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (occupancy !== 5'd0 || {full, empty, gate_open, car_in, car_out, denied, err, fault} !== 8'b0100_0000) begin
            errors++; $display("FAIL async_reset: got occ %0d flags %b want 0 01000000", occupancy, {full, empty, gate_open, car_in, car_out, denied, err, fault});
        end
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        #1;
        rst_n = 1'b1;
        step(0, 0);
        step(0, 0);
        step(0, 0);
        checks++; if ({gate_open, car_in, car_out, fault, err} !== 5'b00000 || occupancy !== 5'd0) begin
            errors++; $display("FAIL post_reset_idle: got %b occ %0d want 00000 0", {gate_open, car_in, car_out, fault, err}, occupancy);
        end
    endtask

    task automatic test_underflow;
        pass(8'b01_11_10_00);
        checks++; if ({car_out, err, empty} !== 3'b111 || occupancy !== 5'd0) begin
            errors++; $display("FAIL underflow: got car_out/err/empty %b occ %0d want 111 0", {car_out, err, empty}, occupancy);
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 110; i++) step(1, 0);
        checks++; if ({fault, gate_open} !== 2'b01) begin errors++; $display("FAIL stall_hold: got fault/gate %b want 01", {fault, gate_open}); end
        step(0, 0);
        checks++; if ({gate_open, car_in, occupancy} !== {1'b0, 1'b0, 5'd0}) begin errors++; $display("FAIL stall_backout: got gate %b car_in %b occ %0d want 0 0 0", gate_open, car_in, occupancy); end
    endtask

    initial begin
        test_reset;
        test_entry;
        test_exit;
        test_fault_backout;
        test_full;
        test_async_reset;
        test_underflow;
        test_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Sequences the parking-lot barrier from two debounced presence sensors. Sensor A is outer, B is inner.
- Decodes entry (A, AB, B, none) and exit (B, AB, A, none) passages with a state machine.
- Maintains the occupancy count, drives the gate-open command, and flags full/empty/fault conditions for display and downstream logic.
- Sits directly after the per-sensor debouncers; its inputs are already clean and synchronous to clk.

Parameters:
- CAPACITY, 16, number of spaces; occupancy saturates here.
- CNT_W, 5, occupancy width; must satisfy 2^CNT_W > CAPACITY.
- TIMEOUT_CYC, 24000000, cycles a passage may stall before fault (only used with PARK_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- sensor_a  in  1  debounced outer sensor, 1 = vehicle present.
- sensor_b  in  1  debounced inner sensor, 1 = vehicle present.
- occupancy  out  CNT_W  cars currently inside.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- gate_open  out  1  barrier raise command.
- car_in  out  1  one-cycle pulse, entry completed.
- car_out  out  1  one-cycle pulse, exit completed.
- denied  out  1  one-cycle pulse, entry attempted while full.
- err  out  1  sticky: overflow/underflow attempt, or fault entered.
- fault  out  1  FSM in FAULT state.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values: state=IDLE, occupancy=0, empty=1, full=0, gate_open=0, all pulses 0, err=0, fault=0. Reset mid-passage aborts the passage with no count change.
- Sensor pair s={a,b}, sampled every cycle. All transitions take effect on the next clock edge, so output latency is 1 cycle after s changes.
- IDLE:
  - s=10 → IN_A. If full, pulse denied in the same update.
  - s=01 → OUT_B.
  - s=11 → FAULT.
  - s=00 → stay.
- Entry path:
  - IN_A: 11→IN_AB; 00→IDLE (backed out, no count); 01→FAULT.
  - IN_AB: 01→IN_B; 10→IN_A (reversing).
  - IN_B: 00→IDLE, pulse car_in, occupancy+1; 11→IN_AB; 10→FAULT.
- Exit path mirrors entry: OUT_B, OUT_BA, OUT_A.
  - OUT_A with 00 → IDLE, pulse car_out, occupancy−1.
  - OUT_B with 00 → IDLE, no count.
- Unlisted inputs hold the current state.
- gate_open:
  - 1 in IN_A/IN_AB/IN_B when not full at passage start; the full status is latched on the IDLE→IN_A transition.
  - 1 in all OUT_* states.
  - 0 in IDLE and FAULT.
- Arithmetic:
  - Entry completion at occupancy==CAPACITY (forced entry): occupancy holds, err set, car_in still pulses.
  - Exit completion at 0: occupancy holds 0, err set, car_out still pulses.
  - full and empty are updated in the same cycle as occupancy.
- FAULT: fault=1 and err set. Leaves to IDLE only after s=00 for one sampled cycle. Occupancy is preserved.
- Pulses are never asserted together. car_in, car_out and denied are each exactly one cycle wide.
- err clears only on reset.

Optional Feature:
- Macro: PARK_TIMEOUT_EN.
- Defined:
  - A stall counter resets on any change of s and on entering IDLE.
  - In any non-IDLE, non-FAULT state, reaching TIMEOUT_CYC cycles with no change forces FAULT (err set, gate_open drops).
- Undefined: no counter is built, and a passage may stall indefinitely. FAULT is reachable only through illegal sensor patterns.

Test Plan:
- Reset, then drive s = 10, 11, 01, 00 (each held 5 cycles) → gate_open=1 from the cycle after s=10; car_in pulses one cycle after s=00; occupancy=1; empty=0.
- Starting at occupancy=3, drive s = 01, 11, 10, 00 → car_out one pulse; occupancy=2; gate_open=1 throughout the passage.
- Fill to 16 entries, then drive s=10 → denied one pulse, gate_open stays 0, full=1. Complete the passage → occupancy stays 16, err=1.
- From IDLE drive s=11 → fault=1, err=1. Then drive s=00 → IDLE next cycle with occupancy unchanged. Separately, drive 10 then 00 → no pulse and no count change (backout).
- Assert rst_n low while in IN_AB → all outputs return to reset values asynchronously; after release, the FSM stays IDLE while s=00.
- With PARK_TIMEOUT_EN and TIMEOUT_CYC=100, hold s=10 for 100 cycles → fault=1 at cycle 100 and gate_open=0. Without the macro, the same stimulus keeps IN_A with fault=0.
